// File: rtl/dcf77_pkg.sv
// dcf77_pkg: DCF77 frame layout, bit positions and slot timing shared by the encoder.
package dcf77_pkg;

  typedef struct packed {
    logic [13:0] civil;
    logic        r;
    logic        a1;
    logic        z1;
    logic        z2;
    logic        a2;
    logic        leap;
    logic [6:0]  minute;
    logic [5:0]  hour;
    logic [5:0]  day;
    logic [2:0]  wday;
    logic [4:0]  month;
    logic [7:0]  year;
  } dcf77_frame_t;

  localparam int BIT_S    = 20;
  localparam int BIT_P1   = 28;
  localparam int BIT_P2   = 35;
  localparam int BIT_P3   = 58;
  localparam int SEC_MARK = 59;
  localparam int SEC_LEAP = 60;

  localparam int SLOTS = 10;
  localparam int W0    = 1;
  localparam int W1    = 2;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } dcf77_state_t;

endpackage

// File: rtl/dcf77_frame_pack.sv
// dcf77_frame_pack: maps a frame struct onto transmitted bits 0..58, with even parity bits.
module dcf77_frame_pack
  import dcf77_pkg::*;
(
  input  dcf77_frame_t      i_frame,
  output logic [BIT_P3:0]   o_bits
);

  // The leap flag only changes minute length, never a transmitted data bit.
  logic w_unused_leap;
  assign w_unused_leap = i_frame.leap;

  always_comb begin
    o_bits = '0;
    o_bits[14:1]              = i_frame.civil;
    o_bits[19:15]             = {i_frame.a2, i_frame.z2, i_frame.z1, i_frame.a1, i_frame.r};
    o_bits[BIT_S]             = 1'b1;
    o_bits[BIT_S+1 +: 7]      = i_frame.minute;
    o_bits[BIT_P1]            = ^i_frame.minute;
    o_bits[BIT_P1+1 +: 6]     = i_frame.hour;
    o_bits[BIT_P2]            = ^i_frame.hour;
    o_bits[BIT_P2+1 +: 22]    = {i_frame.year, i_frame.month, i_frame.wday, i_frame.day};
    o_bits[BIT_P3]            = ^{i_frame.year, i_frame.month, i_frame.wday, i_frame.day};
  end

endmodule

// File: rtl/dcf77_encoder.sv
// dcf77_encoder: DCF77 baseband time-code generator with a one-deep frame shadow register.
// Optional: define DCF77_LEAP_SECOND_EN to honour the frame leap flag (61-second minute).
module dcf77_encoder
  import dcf77_pkg::*;
#(
  parameter int CLK_HZ = 24000000
)(
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         ld_valid,
  output logic         ld_ready,
  input  dcf77_frame_t ld_data,
  output logic         mod,
  output logic         sec_strobe,
  output logic         min_strobe,
  output logic [5:0]   sec_idx,
  output logic         underrun
);

  localparam int              PRE_N     = CLK_HZ / 10;
  localparam int              PRE_W     = (PRE_N > 1) ? $clog2(PRE_N) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_N - 1);
  localparam logic [3:0]      SLOT_LAST = 4'(SLOTS - 1);

  dcf77_state_t     r_state;
  logic [PRE_W-1:0] r_pre, w_pre_nx;
  logic [3:0]       r_slot, w_slot_nx;
  logic [5:0]       r_sec, w_sec_nx, w_sec_last;
  dcf77_frame_t     r_active, r_shadow;
  logic             r_shadow_full;
  logic             r_mod, r_sec_strobe, r_min_strobe, r_underrun;
  logic             w_frame_start, w_accept, w_leap, w_bit, w_data_sec, w_mod_nx;
  logic [BIT_P3:0]  w_bits;

  dcf77_frame_pack u_pack (
    .i_frame (r_active),
    .o_bits  (w_bits)
  );

`ifdef DCF77_LEAP_SECOND_EN
  assign w_leap = r_active.leap;
`else
  assign w_leap = 1'b0;
`endif

  assign w_sec_last = w_leap ? 6'(SEC_LEAP) : 6'(SEC_MARK);
  assign w_accept   = ld_valid && !r_shadow_full;

  // Next counter state; a frame starts on the first RUN cycle and on every sec wrap.
  always_comb begin
    w_pre_nx      = '0;
    w_slot_nx     = '0;
    w_sec_nx      = '0;
    w_frame_start = 1'b1;
    if (r_state == ST_RUN) begin
      w_frame_start = 1'b0;
      if (r_pre != PRE_LAST) begin
        w_pre_nx  = r_pre + 1'b1;
        w_slot_nx = r_slot;
        w_sec_nx  = r_sec;
      end else if (r_slot != SLOT_LAST) begin
        w_slot_nx = r_slot + 1'b1;
        w_sec_nx  = r_sec;
      end else if (r_sec != w_sec_last) begin
        w_sec_nx  = r_sec + 1'b1;
      end else begin
        w_frame_start = 1'b1;
      end
    end
  end

  // Second 0 is a constant 0, so the pre-swap active frame is safe to use at frame start.
  always_comb begin
    w_data_sec = (w_sec_nx < 6'(SEC_MARK)) || (w_leap && (w_sec_nx == 6'(SEC_MARK)));
    w_bit      = (w_sec_nx < 6'(SEC_MARK)) ? w_bits[w_sec_nx] : 1'b0;
    w_mod_nx   = w_data_sec && (w_slot_nx < (w_bit ? 4'(W1) : 4'(W0)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pre         <= '0;
      r_slot        <= '0;
      r_sec         <= '0;
      r_active      <= '0;
      r_shadow      <= '0;
      r_shadow_full <= 1'b0;
      r_mod         <= 1'b0;
      r_sec_strobe  <= 1'b0;
      r_min_strobe  <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_sec_strobe <= 1'b0;
      r_min_strobe <= 1'b0;
      r_underrun   <= 1'b0;
      if (en) begin
        r_state      <= ST_RUN;
        r_pre        <= w_pre_nx;
        r_slot       <= w_slot_nx;
        r_sec        <= w_sec_nx;
        r_mod        <= w_mod_nx;
        r_sec_strobe <= (w_pre_nx == '0) && (w_slot_nx == '0);
        if (w_frame_start) begin
          r_min_strobe <= 1'b1;
          r_underrun   <= !r_shadow_full;
          if (r_shadow_full) begin
            r_active      <= r_shadow;
            r_shadow_full <= 1'b0;
          end
        end
      end else begin
        r_state <= ST_IDLE;
        r_pre   <= '0;
        r_slot  <= '0;
        r_sec   <= '0;
        r_mod   <= 1'b0;
      end
      // Accept only happens with an empty shadow, so it never collides with a consume.
      if (w_accept) begin
        r_shadow      <= ld_data;
        r_shadow_full <= 1'b1;
      end
    end
  end

  assign ld_ready   = !r_shadow_full;
  assign mod        = r_mod;
  assign sec_strobe = r_sec_strobe;
  assign min_strobe = r_min_strobe;
  assign sec_idx    = r_sec;
  assign underrun   = r_underrun;

endmodule
